// File: rtl/puf_uart_tx.sv
// puf_uart_tx: serializes one 16-bit RO-PUF response as a 4-byte UART 8N1 frame.
// Frame byte order: HEADER, seq[7:0], seq[15:8], HEADER ^ seq[7:0] ^ seq[15:8].
//
// Ports:
//   clk       system clock (100 MHz board clock)
//   rst       asynchronous, active-high reset
//   start_tx  transmit request (level); a frame starts on its rising edge while idle
//   seq       PUF response; captured at the trigger edge only
//   tx        UART serial line, idle high, registered
//   busy      high from the trigger edge up to (not including) the done edge
//   done      one-cycle pulse on the edge that ends the last stop bit
module puf_uart_tx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_tx,
    input  logic [15:0] seq,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // Must be >= 2 for the bit timing to be meaningful.
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [31:0]      frame_q, frame_d;
    logic             start_q;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [7:0]       cur_byte;
    logic [2:0]       bit_nxt;
    logic             bit_end;

    assign bit_nxt = bit_idx_q + 3'd1;
    assign bit_end = (baud_cnt_q == CNT_LAST);

    always_comb begin
        cur_byte = 8'h00;
        unique case (byte_idx_q)
            2'd0: cur_byte = frame_q[31:24];
            2'd1: cur_byte = frame_q[23:16];
            2'd2: cur_byte = frame_q[15:8];
            2'd3: cur_byte = frame_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d       = 1'b1;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (start_tx && !start_q) begin
                    frame_d    = {HEADER, seq[7:0], seq[15:8], HEADER ^ seq[7:0] ^ seq[15:8]};
                    byte_idx_d = 2'd0;
                    busy_d     = 1'b1;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d    = StData;
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = cur_byte[0];
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_nxt;
                        tx_d      = cur_byte[bit_nxt];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_cnt_d = '0;
                    if (byte_idx_q == 2'd3) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                    end else begin
                        // Next byte's start bit follows with no idle gap.
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = StStart;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
            start_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            start_q    <= start_tx;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
